// File: rtl/embed_pkg.sv
// Shared types and helpers for the token-embedding engine.
package embed_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_EMIT, S_CLS, S_DONE
  } state_t;

  localparam int ACC_W = 32;

  // Counter/index width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a wide signed value into the signed range of w bits.
  function automatic logic signed [ACC_W-1:0] sat_dw(input logic signed [ACC_W-1:0] v,
                                                     input int w);
    logic signed [ACC_W-1:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/embed_mac_lane.sv
// One embedding column: y = act(sat(sat(x*w >>> FRAC) + b)). Purely combinational.
module embed_mac_lane
  import embed_pkg::*;
#(
  parameter int DW      = 8,
  parameter int FRAC    = 4,
  parameter int RELU_EN = 1
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  logic signed [ACC_W-1:0] xe, we, be, p, s, t;

  // 2*DW <= ACC_W, so the product is exact in the accumulator width.
  assign xe = ACC_W'(signed'(x));
  assign we = ACC_W'(signed'(w));
  assign be = ACC_W'(signed'(b));
  assign p  = xe * we;
  assign s  = sat_dw(p >>> FRAC, DW);
  assign t  = sat_dw(s + be, DW);
  assign y  = (RELU_EN != 0 && t[ACC_W-1]) ? '0 : t[DW-1:0];

endmodule

// File: rtl/embed_linear_engine.sv
// Token-embedding engine: N_TOK linear rows plus a class-token row, streamed one
// row at a time from a single row buffer over valid/ready.
module embed_linear_engine
  import embed_pkg::*;
#(
  parameter int N_TOK     = 15,
  parameter int D_EMB     = 16,
  parameter int DW        = 8,
  parameter int FRAC      = 4,
  parameter int LANES     = 4,
  parameter int RELU_EN   = 1,
  parameter int CLS_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_TOK-1:0][DW-1:0]     x_in,
  input  logic [D_EMB-1:0][DW-1:0]     wt,
  input  logic [D_EMB-1:0][DW-1:0]     bias,
  input  logic [D_EMB-1:0][DW-1:0]     cls_token,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_TOK+1)-1:0]   out_row,
  output logic [D_EMB-1:0][DW-1:0]     out_data,
  output logic                         done
);

  localparam int NGRP = D_EMB / LANES;
  localparam int GW   = cw(NGRP);
  localparam int TW   = cw(N_TOK + 1);
  localparam int XW   = cw(N_TOK);
  localparam int CW   = cw(D_EMB);
  localparam int LW   = cw(LANES);
  localparam int RW   = $clog2(N_TOK + 1);

  if (D_EMB % LANES != 0) begin : g_bad_lanes
    $error("embed_linear_engine: D_EMB must be a multiple of LANES");
  end

  state_t                    state, nstate;
  logic [N_TOK-1:0][DW-1:0]  x_r;
  logic [D_EMB-1:0][DW-1:0]  w_r, b_r, c_r;
  logic [GW-1:0]             grp;
  logic [TW-1:0]             tok;      // token rows computed so far
  logic                      cls_done;
  logic [DW-1:0]             xs;
  logic [LANES-1:0][CW-1:0]  col;
  logic [LANES-1:0][DW-1:0]  lane_y;
  logic                      last_grp;

  assign xs       = x_r[tok[XW-1:0]];
  assign last_grp = (grp == GW'(NGRP - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign col[l] = CW'(int'(grp) * LANES + l);
    embed_mac_lane #(.DW(DW), .FRAC(FRAC), .RELU_EN(RELU_EN)) u_lane (
      .x (xs),
      .w (w_r[col[l]]),
      .b (b_r[col[l]]),
      .y (lane_y[l])
    );
  end

  // Both row orders share one rule: token rows first while any remain, then cls.
  always_comb begin
    nstate    = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: if (start) nstate = S_LOAD;
      S_LOAD: begin
        busy   = 1'b1;
        nstate = (CLS_FIRST != 0) ? S_CLS : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_grp) nstate = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (tok < TW'(N_TOK)) nstate = S_CALC;
          else if (!cls_done)   nstate = S_CLS;
          else                  nstate = S_DONE;
        end
      end
      S_CLS: begin
        busy   = 1'b1;
        nstate = S_EMIT;
      end
      S_DONE: begin
        done   = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      x_r      <= '0;
      w_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      grp      <= '0;
      tok      <= '0;
      cls_done <= 1'b0;
      out_row  <= '0;
      out_data <= '0;
    end else begin
      state <= nstate;
      unique case (state)
        S_IDLE: if (start) begin
          x_r      <= x_in;
          w_r      <= wt;
          b_r      <= bias;
          c_r      <= cls_token;
          grp      <= '0;
          tok      <= '0;
          cls_done <= 1'b0;
          out_row  <= '0;
        end
        S_CALC: begin
          for (int l = 0; l < LANES; l++) out_data[col[l[LW-1:0]]] <= lane_y[l[LW-1:0]];
          grp <= last_grp ? '0 : grp + GW'(1);
          if (last_grp) tok <= tok + TW'(1);
        end
        S_CLS: begin
          out_data <= c_r;
          cls_done <= 1'b1;
        end
        S_EMIT: if (out_ready) out_row <= (nstate == S_DONE) ? '0 : out_row + RW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_embed_linear_engine.sv
// Scoreboard bench: three engine configurations share inputs; expected rows are
// queued at start and popped on each accepted row.
module tb_embed_linear_engine;

  localparam int N_TOK = 15;
  localparam int D_EMB = 16;
  localparam int DW    = 8;
  localparam int ND    = 3;
  localparam int RW    = 4;
  localparam int NROW  = N_TOK + 1;
  // dut0: defaults; dut1: RELU off, cls first, 2 lanes; dut2: cls first, 16 lanes
  localparam logic [ND-1:0] RELU = 3'b101;
  localparam logic [ND-1:0] CLSF = 3'b110;

  typedef logic [RW+D_EMB*DW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ND-1:0] start = '0;
  logic [ND-1:0] ready = '1;
  logic [ND-1:0] busy, valid, done;
  logic [ND-1:0][RW-1:0] orow;
  logic [ND-1:0][D_EMB-1:0][DW-1:0] odata;
  logic [N_TOK-1:0][DW-1:0] x_in = '0;
  logic [D_EMB-1:0][DW-1:0] wt = '0, bias = '0, cls = '0;

  ent_t sbq [ND][$];
  int vectors = 0, miscompares = 0, cyc = 0;
  int vfirst [ND][NROW];
  int acc_cyc [ND], done_cyc [ND], ndone [ND];
  logic [ND-1:0] pv = '0;
  logic [ND-1:0][RW-1:0] prow;

  always #5 clk = ~clk;

  embed_linear_engine u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .x_in(x_in), .wt(wt), .bias(bias),
    .cls_token(cls), .busy(busy[0]), .out_valid(valid[0]), .out_ready(ready[0]),
    .out_row(orow[0]), .out_data(odata[0]), .done(done[0]));

  embed_linear_engine #(.RELU_EN(0), .CLS_FIRST(1), .LANES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .x_in(x_in), .wt(wt), .bias(bias),
    .cls_token(cls), .busy(busy[1]), .out_valid(valid[1]), .out_ready(ready[1]),
    .out_row(orow[1]), .out_data(odata[1]), .done(done[1]));

  embed_linear_engine #(.RELU_EN(1), .CLS_FIRST(1), .LANES(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .x_in(x_in), .wt(wt), .bias(bias),
    .cls_token(cls), .busy(busy[2]), .out_valid(valid[2]), .out_ready(ready[2]),
    .out_row(orow[2]), .out_data(odata[2]), .done(done[2]));

  // Reference arithmetic: floor division by 2^FRAC, two clamps, optional ReLU.
  function automatic logic [DW-1:0] model_elem(input logic [DW-1:0] x, w, b, input logic relu);
    int p, s;
    p = int'($signed(x)) * int'($signed(w));
    s = p / 16;
    if (p < 0 && (p % 16) != 0) s = s - 1;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    s = s + int'($signed(b));
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (relu && s < 0) s = 0;
    return 8'(s);
  endfunction

  task automatic push_job(input int k);
    logic [1:0] ki;
    logic [D_EMB-1:0][DW-1:0] row;
    ki = 2'(k);
    for (int r = 0; r < NROW; r++) begin
      int t;
      t = CLSF[ki] ? r - 1 : r;
      if (t < 0 || t >= N_TOK) row = cls;
      else for (int d = 0; d < D_EMB; d++)
        row[d[3:0]] = model_elem(x_in[t[3:0]], wt[d[3:0]], bias[d[3:0]], RELU[ki]);
      sbq[k].push_back({RW'(r), row});
    end
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit past the rising edge.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      logic [1:0] i;
      i = 2'(k);
      if (valid[i] && (!pv[i] || orow[i] != prow[i])) vfirst[k][orow[i]] = cyc;
      pv[i] = valid[i];
      prow[i] = orow[i];
      if (done[i]) begin done_cyc[k] = cyc; ndone[k]++; end
      if (valid[i] && ready[i]) begin
        if (orow[i] == RW'(N_TOK)) acc_cyc[k] = cyc;
        vectors++;
        if (sbq[k].size() == 0) begin
          miscompares++;
          $display("FAIL sb_extra dut%0d: got row %0d, expected no row", k, orow[i]);
        end else begin
          e = sbq[k].pop_front();
          if ({orow[i], odata[i]} !== e) begin
            miscompares++;
            $display("FAIL sb_row dut%0d: got row %0d data %h, expected row %0d data %h",
                     k, orow[i], odata[i], e[RW+D_EMB*DW-1 -: RW], e[D_EMB*DW-1:0]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic [ND-1:0] m, output int s0);
    s0 = cyc;
    start = m;
    for (int k = 0; k < ND; k++) if (m[k[1:0]]) push_job(k);
    tick();
    start = '0;
  endtask

  task automatic wait_done(input logic [ND-1:0] m, input int budget, input logic rr);
    int n;
    logic all;
    n = 0;
    for (int k = 0; k < ND; k++) ndone[k] = 0;
    all = 1'b0;
    while (!all && n < budget) begin
      if (rr) ready = 3'($urandom);
      tick();
      n++;
      all = 1'b1;
      for (int k = 0; k < ND; k++) if (m[k[1:0]] && ndone[k] == 0) all = 1'b0;
    end
    ready = '1;
    vectors++;
    if (!all) begin
      miscompares++;
      $display("FAIL done_timeout: got done mask incomplete after %0d cycles, expected %b", n, m);
    end
    vectors++;
    if ((busy & m) !== '0 || (done & m) !== '0) begin
      miscompares++;
      $display("FAIL idle_after_done: got busy %b done %b, expected 0 on %b", busy, done, m);
    end
    for (int k = 0; k < ND; k++) if (m[k[1:0]]) begin
      vectors++;
      if (sbq[k].size() != 0) begin
        miscompares++;
        $display("FAIL rows_missing dut%0d: got %0d rows left, expected 0", k, sbq[k].size());
      end
    end
  endtask

  task automatic rand_inputs();
    for (int t = 0; t < N_TOK; t++) x_in[t[3:0]] = 8'($urandom);
    for (int d = 0; d < D_EMB; d++) begin
      wt[d[3:0]] = 8'($urandom);
      bias[d[3:0]] = 8'($urandom);
      cls[d[3:0]] = 8'($urandom);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < ND; k++) begin
      logic [1:0] i;
      i = 2'(k);
      vectors++;
      if (busy[i] !== 1'b0 || valid[i] !== 1'b0 || done[i] !== 1'b0 ||
          orow[i] !== '0 || odata[i] !== '0) begin
        miscompares++;
        $display("FAIL %s dut%0d: got busy %b valid %b done %b row %0d data %h, expected all 0",
                 tag, k, busy[i], valid[i], done[i], orow[i], odata[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_zero("reset_state");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s0;
    x_in = {N_TOK{8'h10}};
    wt   = {D_EMB{8'h20}};
    bias = {D_EMB{8'h08}};
    for (int d = 0; d < D_EMB; d++) cls[d[3:0]] = 8'(d * 7 + 3);
    launch(3'b111, s0);
    vectors++;
    if (busy !== 3'b111) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b, expected 111", busy);
    end
    wait_done(3'b111, 400, 1'b0);
    vectors++;
    if (vfirst[0][0] - s0 != 6) begin
      miscompares++;
      $display("FAIL first_row_latency dut0: got %0d, expected 6", vfirst[0][0] - s0);
    end
    vectors++;
    if (vfirst[0][1] - vfirst[0][0] != 5) begin
      miscompares++;
      $display("FAIL row_period dut0: got %0d, expected 5", vfirst[0][1] - vfirst[0][0]);
    end
    vectors++;
    if (vfirst[1][0] - s0 != 3 || vfirst[2][0] - s0 != 3) begin
      miscompares++;
      $display("FAIL cls_first_latency: got %0d/%0d, expected 3/3",
               vfirst[1][0] - s0, vfirst[2][0] - s0);
    end
    vectors++;
    if (vfirst[1][2] - vfirst[1][1] != 9) begin
      miscompares++;
      $display("FAIL row_period dut1: got %0d, expected 9", vfirst[1][2] - vfirst[1][1]);
    end
    vectors++;
    if (vfirst[2][2] - vfirst[2][1] != 2) begin
      miscompares++;
      $display("FAIL row_period dut2: got %0d, expected 2", vfirst[2][2] - vfirst[2][1]);
    end
    for (int k = 0; k < ND; k++) begin
      vectors++;
      if (done_cyc[k] - acc_cyc[k] != 1) begin
        miscompares++;
        $display("FAIL done_delay dut%0d: got %0d, expected 1", k, done_cyc[k] - acc_cyc[k]);
      end
    end
  endtask

  // Saturation high/low, floor of -1/16 and ReLU on/off in one job.
  task automatic test_saturation();
    int s0;
    for (int t = 0; t < N_TOK; t++)
      x_in[t[3:0]] = (t < 5) ? 8'h7F : (t < 10) ? 8'h80 : 8'h01;
    for (int d = 0; d < D_EMB; d++) begin
      wt[d[3:0]]   = (d < 8) ? 8'h7F : 8'hFF;
      bias[d[3:0]] = (d < 4) ? 8'h7F : 8'h00;
    end
    launch(3'b111, s0);
    wait_done(3'b111, 400, 1'b0);
  endtask

  task automatic test_random();
    int s0;
    for (int j = 0; j < 2; j++) begin
      rand_inputs();
      launch(3'b111, s0);
      wait_done(3'b111, 1500, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    int s0, n, a;
    ent_t e;
    rand_inputs();
    launch(3'b001, s0);
    n = 0;
    while (!(valid[0] && orow[0] == 4'd3) && n < 200) begin tick(); n++; end
    ready[0] = 1'b0;
    e = (sbq[0].size() != 0) ? sbq[0][0] : '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (valid[0] !== 1'b1 || {orow[0], odata[0]} !== e) begin
        miscompares++;
        $display("FAIL stall_hold: got valid %b row %0d data %h, expected row %0d data %h",
                 valid[0], orow[0], odata[0], e[RW+D_EMB*DW-1 -: RW], e[D_EMB*DW-1:0]);
      end
    end
    ready[0] = 1'b1;
    a = cyc;
    tick();
    wait_done(3'b001, 400, 1'b0);
    vectors++;
    if (vfirst[0][4] - a != 5) begin
      miscompares++;
      $display("FAIL release_latency: got %0d, expected 5", vfirst[0][4] - a);
    end
  endtask

  task automatic test_start_ignored_and_reset();
    int s0, n;
    rand_inputs();
    launch(3'b001, s0);
    for (int c = 0; c < 20; c++) tick();
    rand_inputs();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(3'b001, 400, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    vectors++;
    if (busy[0] !== 1'b0 || valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_start: got busy %b valid %b, expected 0 0", busy[0], valid[0]);
    end
    // Reset while row 7 is being computed.
    rand_inputs();
    launch(3'b001, s0);
    n = 0;
    while (!(valid[0] && orow[0] == 4'd6) && n < 200) begin tick(); n++; end
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_zero("mid_job_reset");
    sbq[0].delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    launch(3'b001, s0);
    wait_done(3'b001, 400, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    rand_inputs();
    start[0] = 1'b1;
    push_job(0);
    for (int c = 0; c < 3; c++) tick();
    rand_inputs();
    push_job(0);
    ndone[0] = 0;
    n = 0;
    while (ndone[0] == 0 && n < 400) begin tick(); n++; end
    tick();
    start[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL held_start_restart: got busy %b, expected 1", busy[0]);
    end
    wait_done(3'b001, 400, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_backpressure();
    test_start_ignored_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
